// File: rtl/elevator_request_scheduler_pkg.sv
// Shared definitions for the elevator request scheduler: FSM state encoding,
// travel-direction constants and default sizing of the building/dwell time.
package elevator_pkg;

    localparam int DEFAULT_NUM_FLOORS   = 8;
    localparam int DEFAULT_FLOOR_W      = 3;
    localparam int DEFAULT_SERVE_CYCLES = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        UP    = 2'b01,
        DOWN  = 2'b10,
        SERVE = 2'b11
    } state_t;

    // Remembered direction of the last trip, used by SCAN to keep sweeping
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/elevator_request_scheduler_call_search.sv
// Combinational search over the outstanding-call mask relative to the car.
// Reports whether any call lies above / below the car and the distance to
// the nearest such call on each side (0 when there is none on that side).
module elevator_call_search
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = DEFAULT_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic [FLOOR_W:0]      nearest_up_dist,
    output logic [FLOOR_W:0]      nearest_down_dist
);

    // One extra bit so distances and floor indices never wrap
    localparam int DW = FLOOR_W + 1;

    logic [DW-1:0] car_pos;

    assign car_pos = {1'b0, current_floor};

    // Scan upward for the first call above the car: that one is the nearest
    always_comb begin
        any_above       = 1'b0;
        nearest_up_dist = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (DW'(i) > car_pos) && !any_above) begin
                any_above       = 1'b1;
                nearest_up_dist = DW'(i) - car_pos;
            end
        end
    end

    // Scan downward for the first call below the car: that one is the nearest
    always_comb begin
        any_below         = 1'b0;
        nearest_down_dist = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (DW'(i) < car_pos) && !any_below) begin
                any_below         = 1'b1;
                nearest_down_dist = car_pos - DW'(i);
            end
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Dispatcher in front of the elevator control FSM. Latches floor calls,
// tracks the car position from floor-sensor pulses and picks the travel
// direction with a SCAN policy, holding the car at each served floor for a
// dwell period that door activity or a fresh call at that floor extends.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W      = DEFAULT_FLOOR_W,
    parameter int SERVE_CYCLES = DEFAULT_SERVE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  floor_arrive,
    input  logic                  door_hold,
    output logic                  move_up,
    output logic                  move_down,
    output logic                  extra_waiting,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  serving
);

    localparam int                 DWELL_W    = $clog2(SERVE_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(SERVE_CYCLES);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

    state_t                  state_q;
    logic                    dir_mem_q;
    logic [FLOOR_W-1:0]      current_floor_q;
    logic [NUM_FLOORS-1:0]   pending_q;
    logic [DWELL_W-1:0]      dwell_q;

    logic [FLOOR_W-1:0]      next_floor;
    logic [NUM_FLOORS-1:0]   here_mask;
    logic [NUM_FLOORS-1:0]   next_mask;
    logic [NUM_FLOORS-1:0]   set_mask;
    logic [NUM_FLOORS-1:0]   clr_mask;
    logic [NUM_FLOORS-1:0]   pending_d;
    logic                    call_here;
    logic                    arrive_ok;
    logic                    arrive_hit;
    logic                    latch_block;
    logic                    extra_wait_c;
    logic                    idle_go_up;

    logic                    any_above;
    logic                    any_below;
    logic [FLOOR_W:0]        nearest_up_dist;
    logic [FLOOR_W:0]        nearest_down_dist;

    elevator_call_search #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_call_search (
        .pending           (pending_q),
        .current_floor     (current_floor_q),
        .any_above         (any_above),
        .any_below         (any_below),
        .nearest_up_dist   (nearest_up_dist),
        .nearest_down_dist (nearest_down_dist)
    );

    // The floor the car reaches on the next sensor pulse in its current direction
    assign next_floor = (state_q == DOWN) ? (current_floor_q - FLOOR_W'(1))
                                          : (current_floor_q + FLOOR_W'(1));

    // One-hot masks for the car's floor and the floor it is about to reach
    always_comb begin
        here_mask = '0;
        next_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            here_mask[i] = (FLOOR_W'(i) == current_floor_q);
            next_mask[i] = (FLOOR_W'(i) == next_floor);
        end
    end

    // Arrival qualification, call masking and next outstanding-call mask
    always_comb begin
        call_here    = |(call_req & here_mask);
        arrive_ok    = floor_arrive &&
                       (((state_q == UP)   && (current_floor_q != TOP_FLOOR)) ||
                        ((state_q == DOWN) && (current_floor_q != '0)));
        arrive_hit   = arrive_ok && |(pending_q & next_mask);
        latch_block  = (state_q == IDLE) || (state_q == SERVE);
        set_mask     = latch_block ? (call_req & ~here_mask) : call_req;
        clr_mask     = arrive_ok ? next_mask : '0;
        pending_d    = (pending_q | set_mask) & ~clr_mask;
        extra_wait_c = (state_q == SERVE) && (door_hold || call_here);
        idle_go_up   = any_above && (!any_below || (nearest_up_dist <= nearest_down_dist));
    end

    // Scheduler FSM together with car position, call register and dwell timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            dir_mem_q       <= DIR_UP;
            current_floor_q <= '0;
            pending_q       <= '0;
            dwell_q         <= '0;
        end else begin
            pending_q <= pending_d;
            unique case (state_q)
                IDLE: begin
                    if (call_here) begin
                        state_q <= SERVE;
                        dwell_q <= DWELL_LOAD;
                    end else if (idle_go_up) begin
                        state_q   <= UP;
                        dir_mem_q <= DIR_UP;
                    end else if (any_below) begin
                        state_q   <= DOWN;
                        dir_mem_q <= DIR_DOWN;
                    end
                end
                UP, DOWN: begin
                    if (arrive_ok) begin
                        current_floor_q <= next_floor;
                        if (arrive_hit) begin
                            state_q <= SERVE;
                            dwell_q <= DWELL_LOAD;
                        end
                    end
                end
                SERVE: begin
                    if (extra_wait_c) begin
                        dwell_q <= DWELL_LOAD;
                    end else if (dwell_q != '0) begin
                        dwell_q <= dwell_q - DWELL_W'(1);
                    end else if ((dir_mem_q == DIR_UP) && any_above) begin
                        state_q   <= UP;
                        dir_mem_q <= DIR_UP;
                    end else if (any_below) begin
                        state_q   <= DOWN;
                        dir_mem_q <= DIR_DOWN;
                    end else if (any_above) begin
                        state_q   <= UP;
                        dir_mem_q <= DIR_UP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign move_up       = (state_q == UP);
    assign move_down     = (state_q == DOWN);
    assign serving       = (state_q == SERVE);
    assign extra_waiting = extra_wait_c;
    assign current_floor = current_floor_q;
    assign pending       = pending_q;

endmodule
